// File: rtl/bus_master_if.sv
// Per-master bus front end: converts local burst commands into arbiter
// request/lock signalling and pipelined address/data beats.
module bus_master_if #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned ADDR_INC = 4
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          CMD_VALID,
  output logic          CMD_READY,
  input  logic [AW-1:0] CMD_ADDR,
  input  logic          CMD_WR,
  input  logic [3:0]    CMD_LEN,
  input  logic          CMD_LOCK,
  input  logic [DW-1:0] WD_DATA,
  output logic          WD_REQ,
  output logic [DW-1:0] RD_DATA,
  output logic          RD_VALID,
  output logic          DONE,
  output logic          ERR,
  output logic          MxREQ,
  input  logic          AxGNT,
  output logic          MxTRANS,
  output logic [AW-1:0] MxADDR,
  output logic          MxWR,
  output logic          MxLK,
  output logic          MxLST,
  output logic [DW-1:0] MxWDATA,
  input  logic [DW-1:0] SxRDATA,
  input  logic          MsRDY,
  input  logic          MsERR
);

  localparam int unsigned RW = 5;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_ADDR, S_LASTD, S_HOLD} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic          r_wr, w_wr_nxt;
  logic          r_lock, w_lock_nxt;
  logic [RW-1:0] r_rem, w_rem_nxt;
  logic          r_req, w_req_nxt;
  logic          r_dph, w_dph_nxt;
  logic          r_done, w_done_nxt;
  logic          r_err, w_err_nxt;
  logic          r_wfirst, w_wfirst_nxt;
  logic [DW-1:0] r_wdata, w_wdata_nxt;

  logic w_dph_end;
  logic w_err;
  logic w_rd_ok;
  logic w_addr_acc;

  // A single MsRDY advances both the pending data phase and the current address phase
  assign w_dph_end  = r_dph & MsRDY;
  assign w_err      = w_dph_end & MsERR;
  assign w_rd_ok    = w_dph_end & ~MsERR & ~r_wr;
  assign w_addr_acc = (r_state == S_ADDR) & MsRDY & ~w_err;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_wr     <= 1'b0;
      r_lock   <= 1'b0;
      r_rem    <= '0;
      r_req    <= 1'b0;
      r_dph    <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_wfirst <= 1'b0;
      r_wdata  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_wr     <= w_wr_nxt;
      r_lock   <= w_lock_nxt;
      r_rem    <= w_rem_nxt;
      r_req    <= w_req_nxt;
      r_dph    <= w_dph_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_wfirst <= w_wfirst_nxt;
      r_wdata  <= w_wdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_addr_nxt   = r_addr;
    w_wr_nxt     = r_wr;
    w_lock_nxt   = r_lock;
    w_rem_nxt    = r_rem;
    w_req_nxt    = r_req;
    w_dph_nxt    = r_dph & ~MsRDY;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    w_wfirst_nxt = 1'b0;
    w_wdata_nxt  = r_wfirst ? WD_DATA : r_wdata;

    unique case (r_state)
      S_IDLE: begin
        if (CMD_VALID) begin
          w_addr_nxt  = CMD_ADDR;
          w_wr_nxt    = CMD_WR;
          w_lock_nxt  = CMD_LOCK;
          w_rem_nxt   = RW'(CMD_LEN) + RW'(1);
          w_req_nxt   = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        w_req_nxt = 1'b1;
        if (AxGNT && MsRDY) w_state_nxt = S_ADDR;
      end
      S_ADDR: begin
        if (w_addr_acc) begin
          w_addr_nxt   = r_addr + AW'(ADDR_INC);
          w_rem_nxt    = r_rem - RW'(1);
          w_dph_nxt    = 1'b1;
          w_wfirst_nxt = r_wr;
          if (r_rem == RW'(1)) begin
            w_state_nxt = S_LASTD;
            w_req_nxt   = r_lock;
          end
        end
      end
      S_LASTD: begin
        if (w_dph_end && !MsERR) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = r_lock ? S_HOLD : S_IDLE;
        end
      end
      S_HOLD: begin
        // Grant is retained while locked; skip arbitration if still granted
        if (CMD_VALID) begin
          w_addr_nxt  = CMD_ADDR;
          w_wr_nxt    = CMD_WR;
          w_lock_nxt  = CMD_LOCK;
          w_rem_nxt   = RW'(CMD_LEN) + RW'(1);
          w_state_nxt = AxGNT ? S_ADDR : S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Slave error aborts the burst and releases the bus, including a held lock
    if (w_err) begin
      w_state_nxt  = S_IDLE;
      w_req_nxt    = 1'b0;
      w_lock_nxt   = 1'b0;
      w_dph_nxt    = 1'b0;
      w_wfirst_nxt = 1'b0;
      w_err_nxt    = 1'b1;
    end
  end

  assign CMD_READY = (r_state == S_IDLE) | (r_state == S_HOLD);
  assign MxREQ     = r_req;
  assign MxTRANS   = (r_state == S_ADDR);
  assign MxADDR    = r_addr;
  assign MxWR      = r_wr;
  assign MxLST     = (r_state == S_ADDR) & (r_rem == RW'(1));
  assign MxLK      = MxLST & r_lock;
  assign WD_REQ    = w_addr_acc & r_wr;
  assign MxWDATA   = r_wfirst ? WD_DATA : r_wdata;
  assign RD_VALID  = w_rd_ok;
  assign RD_DATA   = w_rd_ok ? SxRDATA : '0;
  assign DONE      = r_done;
  assign ERR       = r_err;

endmodule

// File: doc/bus_master_if.md
Name: bus_master_if

Overview:
- Per-master bus interface that sits directly upstream of the bus arbiter and master-side mux.
- Turns local burst commands (from a DMA engine or UART core) into request/lock/last signalling and pipelined address/data beats.
- Drives MxREQ/MxLK/MxLST into the arbiter and consumes this master's grant bit.
- Bus is pipelined: the address phase of beat n overlaps the data phase of beat n-1; every phase advances only when MsRDY=1.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- ADDR_INC, 4, byte increment per beat (incrementing burst).

Ports:
- CLK  in  1  clock
- nRST  in  1  async active-low reset
- CMD_VALID  in  1  local command valid
- CMD_READY  out  1  command accepted when VALID&READY
- CMD_ADDR  in  AW  start address
- CMD_WR  in  1  1=write, 0=read
- CMD_LEN  in  4  beats-1 (1..16 beats)
- CMD_LOCK  in  1  keep bus after this burst for the next command
- WD_DATA  in  DW  write data, valid the cycle after WD_REQ
- WD_REQ  out  1  pop pulse for one write word
- RD_DATA  out  DW  read data
- RD_VALID  out  1  RD_DATA valid
- DONE  out  1  one-cycle pulse on burst completion
- ERR  out  1  one-cycle pulse on aborted burst
- MxREQ  out  1  bus request to arbiter
- AxGNT  in  1  this master's grant bit
- MxTRANS  out  1  active address phase
- MxADDR  out  AW  beat address
- MxWR  out  1  beat direction
- MxLK  out  1  lock, valid with MxLST
- MxLST  out  1  last address beat of burst
- MxWDATA  out  DW  write data in data phase
- SxRDATA  in  DW  read data from bus
- MsRDY  in  1  phase completes
- MsERR  in  1  slave error (data phase)

Behaviour:
- Reset (async, nRST=0): state IDLE; every registered output 0 (MxREQ, MxTRANS, MxADDR, MxWR, MxLK, MxLST, MxWDATA, RD_DATA, RD_VALID, DONE, ERR, WD_REQ). CMD_READY=1 immediately after reset releases.
- Reset mid-burst: abort immediately. No DONE or ERR pulse.
- States: IDLE, REQ, ADDR, LASTD, HOLD.
- IDLE:
  - CMD_READY=1.
  - On CMD_VALID: latch addr/wr/len/lock into working registers, remaining=CMD_LEN+1, MxREQ=1 next cycle, go to REQ.
- REQ:
  - CMD_READY=0, MxREQ=1.
  - AxGNT=1 & MsRDY=1 in the same cycle -> go to ADDR next cycle.
  - AxGNT dropping before MsRDY -> remain in REQ.
- ADDR:
  - MxTRANS=1, MxADDR=current addr, MxWR=latched wr.
  - MxLST=1 iff remaining==1; MxLK=lock & MxLST.
  - Beat accepted when MsRDY=1: addr+=ADDR_INC (mod 2^AW), remaining-=1.
  - Write beat accepted -> WD_REQ pulse same cycle; WD_DATA is captured into MxWDATA the next cycle and held through that data phase.
  - Last beat accepted -> go to LASTD. MxREQ drops to 0 the same edge unless lock=1.
- Data phase, one cycle after each accepted address, completes on MsRDY:
  - Read: RD_VALID=1 and RD_DATA=SxRDATA for one cycle per completed data phase.
  - Exactly len+1 RD_VALID pulses, or len+1 WD_REQ pulses, per successful burst.
- LASTD:
  - MxTRANS=0, MxLST=0.
  - Final data phase completes on MsRDY: DONE pulse next cycle.
  - lock=0 -> IDLE; lock=1 -> HOLD.
- HOLD:
  - MxREQ=1 (grant retained by arbiter), CMD_READY=1.
  - On CMD_VALID: latch the new command and go directly to ADDR; no re-arbitration.
  - If AxGNT=0 at command acceptance, go to REQ instead.
- Error:
  - MsERR=1 with MsRDY=1 in any data phase: ERR pulse next cycle.
  - Same edge: MxTRANS=0, MxREQ=0, MxLST=0, MxLK=0.
  - Remaining beats are discarded, no DONE; next state IDLE. This applies in HOLD too: lock is dropped.
  - MsERR is ignored while not owning a data phase.
- DONE and ERR are mutually exclusive.
- No 1 KB boundary check; the command source guarantees bursts stay legal.

Test Plan:
- Single read (CMD_LEN=0, addr 0x100, AxGNT tied 1, MsRDY 1) -> MxREQ at cycle 1, MxTRANS+MxLST at cycle 2 with MxADDR=0x100, RD_VALID at cycle 3, DONE at cycle 4.
- 4-beat write at 0x200 with MsRDY stalled 2 cycles on beat 2 -> MxADDR sequence 0x200/204/208/20C, each address held through the stall, 4 WD_REQ pulses, MxLST only on 0x20C, MxWDATA matches pushed words.
- Grant delayed 5 cycles -> MxREQ held, MxTRANS=0 throughout, CMD_READY=0; first beat issues the cycle after AxGNT&MsRDY.
- MsERR on data phase of beat 2 of 8-beat read -> ERR pulse once, exactly 1 RD_VALID, MxREQ/MxTRANS=0 next cycle, no DONE, back to IDLE.
- Locked 2-beat read then 2-beat write -> MxLK=1 with first burst's MxLST, MxREQ never drops, second burst starts without REQ state, 2 DONE pulses.
- nRST asserted during beat 3 of 16 -> all outputs 0 asynchronously; after release CMD_READY=1 and a fresh 1-beat command completes normally.
